// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronised RX, midpoint sampling, one-entry valid/ready output register.
// Latency: o_valid rises one cycle after the stop-bit sample, about 2 + HALF + 9*CPB cycles after the start edge.
// Backpressure: none toward the line; a byte completing while the register is still full is dropped and o_overrun pulses.
//
// Ports:
//   i_clk, i_rst        clock (posedge) and asynchronous active-high reset
//   i_rx                serial line, asynchronous, idle high
//   o_data, o_valid     received byte and its valid flag
//   i_ready             consumer accepts o_data when o_valid & i_ready at an edge
//   o_frame_err         one-cycle pulse: stop bit sampled low
//   o_overrun           one-cycle pulse: completed byte dropped, register full
module uart_rx #(
  parameter int CLK_FREQ = 250000,
  parameter int BAUD     = 9600
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);

  localparam logic [CW-1:0] CNT_FULL = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          rx_meta, rxs;
  logic          cnt_zero;
  logic          stop_good, stop_bad;

  // Synchroniser flops reset to the idle level so reset never looks like a start bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rxs     <= rx_meta;
    end
  end

  // State register together with the per-frame datapath.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
    end
  end

  assign cnt_zero = (cnt == '0);

  // Next-state logic. Every timed state counts down and acts on the edge where the counter is zero.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    case (state)
      S_IDLE: begin
        if (!rxs) begin
          state_nxt = S_START;
          cnt_nxt   = CNT_HALF;
        end
      end
      S_START: begin
        if (!cnt_zero) begin
          cnt_nxt = cnt - 1'b1;
        end else if (!rxs) begin
          state_nxt   = S_DATA;
          cnt_nxt     = CNT_FULL;
          bit_idx_nxt = 3'd0;
        end else begin
          // Line went high again before mid-start-bit: treat as a glitch.
          state_nxt = S_IDLE;
        end
      end
      S_DATA: begin
        if (!cnt_zero) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          shift_nxt = {rxs, shift[7:1]};
          cnt_nxt   = CNT_FULL;
          if (bit_idx == 3'd7) begin
            state_nxt = S_STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (!cnt_zero) begin
          cnt_nxt = cnt - 1'b1;
        end else if (rxs) begin
          // Back to IDLE at mid-stop so a back-to-back start bit is not missed.
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        // A break or stuck-low line must return high before another frame is hunted.
        if (rxs) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Stop-sample strobes feeding the output register.
  always_comb begin
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    if (state == S_STOP && cnt_zero) begin
      stop_good = rxs;
      stop_bad  = !rxs;
    end
  end

  // One-entry output register. A completed byte may load on the same edge the old one is taken.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data      <= 8'h00;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= stop_bad;
      o_overrun   <= 1'b0;
      if (stop_good) begin
        if (!o_valid || i_ready) begin
          o_data  <= shift;
          o_valid <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven at 26 cycles/bit, checked every cycle
// against a frame-level timing model, plus hand-computed expectations per scenario.
module tb_uart_rx;

  localparam int CPB  = 26;
  localparam int HALF = 13;

  logic       i_clk;
  logic       i_rst;
  logic       i_rx;
  logic       i_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;

  uart_rx #(
    .CLK_FREQ(250000),
    .BAUD    (9600)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rx       (i_rx),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, req, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // ---------------- Frame-level model ----------------
  // The line is seen through two idle-high delay stages. A frame is timed by its offset
  // from the first low seen while hunting: start check at HALF, data bit k-1 at HALF+k*CPB,
  // stop at HALF+9*CPB.
  logic       m_s1 = 1'b1, m_s2 = 1'b1;
  int         m_mode = 0;   // 0 hunting, 1 in frame, 2 waiting for line high
  int         m_off = 0;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] m_last = 8'h00;
  int         m_ngood = 0;
  logic       exp_valid = 1'b0, exp_fe = 1'b0, exp_ov = 1'b0;
  logic [7:0] exp_data = 8'h00;

  always @(posedge i_clk or posedge i_rst) begin : model
    int         md, of, k;
    logic [7:0] b, d;
    logic       r, v, fe, ov, good;
    if (i_rst) begin
      m_s1 <= 1'b1; m_s2 <= 1'b1; m_mode <= 0; m_off <= 0; m_byte <= 8'h00;
      exp_valid <= 1'b0; exp_data <= 8'h00; exp_fe <= 1'b0; exp_ov <= 1'b0;
    end else begin
      r = m_s2; md = m_mode; of = m_off; b = m_byte; v = exp_valid; d = exp_data;
      fe = 1'b0; ov = 1'b0; good = 1'b0;
      case (md)
        0: if (!r) begin md = 1; of = 0; end
        1: begin
          of = of + 1;
          if (of == HALF && r) begin
            md = 0;
          end else if (of > HALF && (of - HALF) % CPB == 0) begin
            k = (of - HALF) / CPB;
            if (k <= 8) begin
              b[k-1] = r;
            end else if (r) begin
              good = 1'b1; md = 0;
            end else begin
              fe = 1'b1; md = 2;
            end
          end
        end
        default: if (r) md = 0;
      endcase
      if (good) begin
        if (!v || i_ready) begin d = b; v = 1'b1; end
        else ov = 1'b1;
      end else if (v && i_ready) begin
        v = 1'b0;
      end
      m_s2 <= m_s1; m_s1 <= i_rx; m_mode <= md; m_off <= of; m_byte <= b;
      exp_valid <= v; exp_data <= d; exp_fe <= fe; exp_ov <= ov;
      if (good) begin m_last <= b; m_ngood <= m_ngood + 1; end
    end
  end

  // ---------------- Per-cycle compare and event log ----------------
  int         n_rise = 0, n_vhigh = 0, n_fe = 0, n_ov = 0, last_rise = 0;
  logic       prev_v = 1'b0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] rx_log[$];

  always @(negedge i_clk) begin
    check("cyc_valid", {31'd0, o_valid}, {31'd0, exp_valid});
    check("cyc_frame_err", {31'd0, o_frame_err}, {31'd0, exp_fe});
    check("cyc_overrun", {31'd0, o_overrun}, {31'd0, exp_ov});
    if (exp_valid) check("cyc_data", {24'd0, o_data}, {24'd0, exp_data});
    if (o_valid) n_vhigh++;
    if (o_valid && !prev_v) begin
      n_rise++; last_rise = cyc; last_data = o_data; rx_log.push_back(o_data);
    end
    prev_v = o_valid;
    if (o_frame_err) n_fe++;
    if (o_overrun) n_ov++;
  end

  // ---------------- Stimulus ----------------
  int last_fall = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    last_fall = cyc;
    i_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      tick(CPB);
    end
    i_rx = stop;
    tick(CPB);
  endtask

  initial begin
    int r0, f0, o0, v0;
    logic [7:0] seq [4];
    logic [7:0] aborted;
    seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h55; seq[3] = 8'hAA;
    aborted = 8'h99;

    i_rst = 1'b1; i_rx = 1'b1; i_ready = 1'b1;
    tick(3);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_data", {24'd0, o_data}, 32'd0);
    check("rst_frame_err", {31'd0, o_frame_err}, 32'd0);
    check("rst_overrun", {31'd0, o_overrun}, 32'd0);
    i_rst = 1'b0;
    tick(10);

    // Ideal 0xA5 frame: 3 cycles to reach the FSM, then HALF + 9*CPB = 247.
    r0 = n_rise; v0 = n_vhigh;
    send_frame(8'hA5, 1'b1);
    tick(20);
    check("a5_count", n_rise, r0 + 1);
    check("a5_data", {24'd0, last_data}, 32'hA5);
    check("a5_latency", last_rise - last_fall, 250);
    check("a5_pulse_width", n_vhigh - v0, 1);
    check("a5_model_byte", {24'd0, m_last}, 32'hA5);
    check("a5_model_count", m_ngood, 1);
    check("a5_no_errors", n_fe + n_ov, 0);

    // Short glitch, then 0x3C.
    r0 = n_rise; f0 = n_fe;
    i_rx = 1'b0; tick(5); i_rx = 1'b1; tick(40);
    check("glitch_no_valid", n_rise, r0);
    check("glitch_no_fe", n_fe, f0);
    send_frame(8'h3C, 1'b1);
    tick(20);
    check("post_glitch_count", n_rise, r0 + 1);
    check("post_glitch_data", {24'd0, last_data}, 32'h3C);

    // Framing error: stop bit low, line held low 40 more cycles, then 0x7E.
    r0 = n_rise; f0 = n_fe;
    send_frame(8'h3C, 1'b0);
    tick(40);
    i_rx = 1'b1;
    tick(20);
    check("fe_pulse_once", n_fe, f0 + 1);
    check("fe_no_valid", n_rise, r0);
    send_frame(8'h7E, 1'b1);
    tick(20);
    check("post_fe_data", {24'd0, last_data}, 32'h7E);
    check("post_fe_count", n_rise, r0 + 1);

    // Overrun: two frames with the consumer stalled.
    i_ready = 1'b0; o0 = n_ov;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(5);
    check("ovr_valid_held", {31'd0, o_valid}, 32'd1);
    check("ovr_data_held", {24'd0, o_data}, 32'h11);
    check("ovr_pulse_once", n_ov, o0 + 1);
    i_ready = 1'b1; tick(1); i_ready = 1'b0; tick(2);
    check("ovr_drain", {31'd0, o_valid}, 32'd0);

    // Reset in the middle of data bit 4, then 0x5A.
    i_ready = 1'b1; r0 = n_rise;
    i_rx = 1'b0; tick(CPB);
    for (int i = 0; i < 4; i++) begin
      i_rx = aborted[i]; tick(CPB);
    end
    i_rx = aborted[4]; tick(10);
    i_rst = 1'b1; i_rx = 1'b1;
    tick(1);
    check("midrst_valid", {31'd0, o_valid}, 32'd0);
    check("midrst_data", {24'd0, o_data}, 32'd0);
    check("midrst_fe_ov", {30'd0, o_frame_err, o_overrun}, 32'd0);
    tick(2);
    i_rst = 1'b0;
    tick(30);
    check("midrst_no_byte", n_rise, r0);
    send_frame(8'h5A, 1'b1);
    tick(20);
    check("post_rst_data", {24'd0, last_data}, 32'h5A);
    check("post_rst_count", n_rise, r0 + 1);

    // Back-to-back stream at full line rate.
    r0 = n_rise; f0 = n_fe; o0 = n_ov;
    for (int i = 0; i < 4; i++) send_frame(seq[i], 1'b1);
    tick(20);
    check("stream_count", n_rise, r0 + 4);
    for (int i = 0; i < 4; i++) begin
      if (rx_log.size() > r0 + i) check($sformatf("stream_byte%0d", i), {24'd0, rx_log[r0+i]}, {24'd0, seq[i]});
      else check($sformatf("stream_byte%0d_missing", i), 32'd0, 32'd1);
    end
    check("stream_no_errors", (n_fe - f0) + (n_ov - o0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
